// File: rtl/zxuno_regbus_if.sv
// Z80 I/O-side and peripheral-side signals of the ZX-UNO register bus.
// The master modport drives the CPU and peripheral inputs. The slave modport is the controller.
interface zxuno_regbus_if #(
  parameter int NSRC = 8
);
  logic [15:0]       cpu_a;
  logic [7:0]        cpu_din;
  logic              cpu_iorq_n;
  logic              cpu_rd_n;
  logic              cpu_wr_n;
  logic              cpu_m1_n;
  logic [NSRC-1:0]   src_oe;
  logic [NSRC*8-1:0] src_dout;
  logic [7:0]        zxuno_addr;
  logic              zxuno_regrd;
  logic              zxuno_regwr;
  logic [7:0]        zxuno_regdata;
  logic              regaddr_changed;
  logic [7:0]        cpu_dout;
  logic              cpu_oe;
  logic              bus_conflict;

  modport master (
    output cpu_a, cpu_din, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, src_oe, src_dout,
    input  zxuno_addr, zxuno_regrd, zxuno_regwr, zxuno_regdata, regaddr_changed,
           cpu_dout, cpu_oe, bus_conflict
  );

  modport slave (
    input  cpu_a, cpu_din, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, src_oe, src_dout,
    output zxuno_addr, zxuno_regrd, zxuno_regwr, zxuno_regdata, regaddr_changed,
           cpu_dout, cpu_oe, bus_conflict
  );
endinterface

// File: rtl/zxuno_regbus_ctrl.sv
// ZX-UNO register bus sequencer: decodes FC3Bh/FD3Bh and issues one strobe per Z80 I/O cycle.
// All outputs are registered. Read data follows the sources with 1 cycle of latency.
module zxuno_regbus_ctrl #(
  parameter int          NSRC       = 8,
  parameter logic [15:0] ADDRPORT   = 16'hFC3B,
  parameter logic [15:0] DATAPORT   = 16'hFD3B,
  parameter logic [7:0]  ADDR_RESET = 8'h00
) (
  input logic           clk,
  input logic           rst,
  zxuno_regbus_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_DONE, WAIT_END} state_t;
  state_t state;

  logic       hit_addr, hit_data, acc_ok, rd_hold, multi_oe, found;
  logic [7:0] sel_dout;

  assign hit_addr = (bus.cpu_a == ADDRPORT);
  assign hit_data = (bus.cpu_a == DATAPORT);
  // Requiring exactly one of rd_n/wr_n low rejects the illegal both-low case.
  assign acc_ok   = !bus.cpu_iorq_n && bus.cpu_m1_n && (hit_addr || hit_data)
                    && (bus.cpu_rd_n ^ bus.cpu_wr_n);
  assign rd_hold  = !bus.cpu_iorq_n && !bus.cpu_rd_n;
  assign multi_oe = |(bus.src_oe & (bus.src_oe - {{(NSRC-1){1'b0}}, 1'b1}));

  always_comb begin
    sel_dout = 8'hFF;
    found    = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (!found && bus.src_oe[k]) begin
        sel_dout = bus.src_dout[k*8 +: 8];
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= WAIT_END;
      bus.zxuno_addr      <= ADDR_RESET;
      bus.zxuno_regdata   <= 8'h00;
      bus.zxuno_regrd     <= 1'b0;
      bus.zxuno_regwr     <= 1'b0;
      bus.regaddr_changed <= 1'b0;
      bus.cpu_dout        <= 8'hFF;
      bus.cpu_oe          <= 1'b0;
      bus.bus_conflict    <= 1'b0;
    end else begin
      bus.zxuno_regwr     <= 1'b0;
      bus.regaddr_changed <= 1'b0;
      if (bus.zxuno_regrd && multi_oe)
        bus.bus_conflict <= 1'b1;

      case (state)
        IDLE: begin
          if (acc_ok) begin
            if (!bus.cpu_wr_n) begin
              state <= WR_DONE;
              if (hit_addr) begin
                bus.zxuno_addr      <= bus.cpu_din;
                bus.regaddr_changed <= 1'b1;
                bus.bus_conflict    <= 1'b0;
              end else begin
                bus.zxuno_regdata <= bus.cpu_din;
                bus.zxuno_regwr   <= 1'b1;
              end
            end else if (hit_addr) begin
              state        <= RD_ADDR;
              bus.cpu_oe   <= 1'b1;
              bus.cpu_dout <= bus.zxuno_addr;
            end else begin
              state           <= RD_DATA;
              bus.cpu_oe      <= 1'b1;
              bus.zxuno_regrd <= 1'b1;
              bus.cpu_dout    <= sel_dout;
            end
          end
        end
        RD_ADDR: begin
          if (rd_hold) begin
            bus.cpu_dout <= bus.zxuno_addr;
          end else begin
            state        <= IDLE;
            bus.cpu_oe   <= 1'b0;
            bus.cpu_dout <= 8'hFF;
          end
        end
        RD_DATA: begin
          if (rd_hold) begin
            bus.cpu_dout <= sel_dout;
          end else begin
            state           <= IDLE;
            bus.cpu_oe      <= 1'b0;
            bus.cpu_dout    <= 8'hFF;
            bus.zxuno_regrd <= 1'b0;
          end
        end
        WR_DONE:  state <= WAIT_END;
        WAIT_END: if (bus.cpu_iorq_n) state <= IDLE;
        default:  state <= WAIT_END;
      endcase
    end
  end

endmodule

// File: tb/tb_zxuno_regbus_ctrl.sv
// Scoreboard bench for zxuno_regbus_ctrl. Stimulus queues the strobes each I/O cycle should produce.
// A negedge monitor pops and compares them as they appear.
module tb_zxuno_regbus_ctrl;

  localparam logic [1:0] K_ADDR = 2'd0, K_WR = 2'd1, K_RD = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [9:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zxuno_regbus_if #(.NSRC(8)) bus ();

  zxuno_regbus_ctrl #(
    .NSRC(8), .ADDRPORT(16'hFC3B), .DATAPORT(16'hFD3B), .ADDR_RESET(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ev_t exp_q[$];
  int  checks   = 0;
  int  errors   = 0;
  int  rd_rises = 0;
  int  rd_exp   = 0;

  logic       prev_rac = 1'b0, prev_wr = 1'b0, prev_oe = 1'b0, prev_rd = 1'b0;
  logic       last_rd = 1'b0, last_conf = 1'b0;
  logic [7:0] last_dout = 8'hFF;

  task automatic check_ev(input string name, input logic [1:0] kind, input logic [9:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event kind=%0d val=%h, none required", name, kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL %s got kind=%0d val=%h required kind=%0d val=%h",
                 name, kind, val, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.regaddr_changed && !prev_rac)
      check_ev("addr_write", K_ADDR, {2'b00, bus.zxuno_addr});
    if (bus.regaddr_changed && prev_rac) begin
      checks++; errors++;
      $display("FAIL rac_width got high 2+ cycles required 1");
    end
    if (bus.zxuno_regwr && !prev_wr)
      check_ev("data_write", K_WR, {2'b00, bus.zxuno_regdata});
    if (bus.zxuno_regwr && prev_wr) begin
      checks++; errors++;
      $display("FAIL regwr_width got high 2+ cycles required 1");
    end
    if (prev_oe && !bus.cpu_oe) begin
      check_ev("read", K_RD, {last_rd, last_conf, last_dout});
      checks++;
      if (bus.cpu_dout !== 8'hFF || bus.zxuno_regrd !== 1'b0) begin
        errors++;
        $display("FAIL read_end got dout=%h regrd=%b required dout=ff regrd=0",
                 bus.cpu_dout, bus.zxuno_regrd);
      end
    end
    if (bus.zxuno_regrd && !prev_rd) rd_rises++;
    prev_rac  = bus.regaddr_changed;
    prev_wr   = bus.zxuno_regwr;
    prev_oe   = bus.cpu_oe;
    prev_rd   = bus.zxuno_regrd;
    last_rd   = bus.zxuno_regrd;
    last_conf = bus.bus_conflict;
    last_dout = bus.cpu_dout;
  end

  // One Z80 I/O cycle: strobes held for 'hold' cycles, cpu_a switched to mid_a after the first.
  task automatic io(input logic [15:0] a, input logic [7:0] d, input bit wr,
                    input int hold, input logic [15:0] mid_a);
    @(negedge clk);
    bus.cpu_a      = a;
    bus.cpu_din    = d;
    bus.cpu_iorq_n = 1'b0;
    if (wr) bus.cpu_wr_n = 1'b0;
    else    bus.cpu_rd_n = 1'b0;
    @(negedge clk);
    bus.cpu_a = mid_a;
    repeat (hold - 1) @(negedge clk);
    bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
  endtask

  task automatic out_addr(input logic [7:0] d);
    exp_q.push_back('{K_ADDR, {2'b00, d}});
    io(16'hFC3B, d, 1'b1, 3, 16'hFC3B);
  endtask

  task automatic out_data(input logic [7:0] d);
    exp_q.push_back('{K_WR, {2'b00, d}});
    io(16'hFD3B, d, 1'b1, 3, 16'hFD3B);
  endtask

  task automatic in_data(input logic [9:0] expv);
    exp_q.push_back('{K_RD, expv});
    rd_exp++;
    io(16'hFD3B, 8'h00, 1'b0, 3, 16'hFD3B);
  endtask

  initial begin
    bus.cpu_a      = 16'h0000;
    bus.cpu_din    = 8'h00;
    bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_m1_n   = 1'b1;
    bus.src_oe     = '0;
    bus.src_dout   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checks++;
    if (bus.zxuno_addr !== 8'h00 || bus.zxuno_regdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs got addr=%h regdata=%h required 00 00", bus.zxuno_addr, bus.zxuno_regdata);
    end
    checks++;
    if (bus.cpu_dout !== 8'hFF || bus.cpu_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus got dout=%h oe=%b required ff 0", bus.cpu_dout, bus.cpu_oe);
    end
    checks++;
    if ({bus.zxuno_regrd, bus.zxuno_regwr, bus.regaddr_changed, bus.bus_conflict} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b required 0000",
               {bus.zxuno_regrd, bus.zxuno_regwr, bus.regaddr_changed, bus.bus_conflict});
    end

    // Address writes, including a repeat of the same value.
    out_addr(8'hFF);
    out_addr(8'hFF);
    out_addr(8'h01);
    out_data(8'h5A);

    // Two sources driving: lowest index wins, conflict stays set until the next address write.
    bus.src_dout[15:8]  = 8'h11;
    bus.src_dout[23:16] = 8'h22;
    bus.src_oe          = 8'b0000_0110;
    in_data({1'b1, 1'b1, 8'h11});
    bus.src_oe = 8'b0000_0100;
    in_data({1'b1, 1'b1, 8'h22});
    out_addr(8'hA5);

    bus.src_oe = 8'b0000_0000;
    in_data({1'b1, 1'b0, 8'hFF});
    // Address-port read; cpu_a moves mid-cycle without retargeting it.
    exp_q.push_back('{K_RD, {1'b0, 1'b0, 8'hA5}});
    io(16'hFC3B, 8'h00, 1'b0, 3, 16'hFD3B);

    bus.src_oe = 8'b0000_0001;
    for (int i = 0; i < 16; i++) begin
      bus.src_dout[7:0] = 8'(8'h40 + i);
      in_data({1'b1, 1'b0, 8'(8'h40 + i)});
    end
    bus.src_oe = 8'b0000_0000;

    // INTA at the address port: no strobe.
    bus.cpu_m1_n = 1'b0;
    io(16'hFC3B, 8'h99, 1'b1, 3, 16'hFC3B);
    bus.cpu_m1_n = 1'b1;

    // Both rd_n and wr_n low: illegal, no strobe.
    @(negedge clk);
    bus.cpu_a = 16'hFD3B; bus.cpu_din = 8'h66;
    bus.cpu_iorq_n = 1'b0; bus.cpu_rd_n = 1'b0; bus.cpu_wr_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.cpu_iorq_n = 1'b1; bus.cpu_rd_n = 1'b1; bus.cpu_wr_n = 1'b1;

    // Reset lands on a write that is still in progress and must not be replayed afterwards.
    @(negedge clk);
    bus.cpu_a = 16'hFC3B; bus.cpu_din = 8'h77;
    bus.cpu_iorq_n = 1'b0; bus.cpu_wr_n = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    bus.cpu_iorq_n = 1'b1; bus.cpu_wr_n = 1'b1;
    checks++;
    if (bus.zxuno_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_midwrite addr got %h required 00", bus.zxuno_addr);
    end
    out_addr(8'h3C);

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d unconsumed required 0", exp_q.size());
    end
    checks++;
    if (rd_rises != rd_exp) begin
      errors++;
      $display("FAIL regrd_periods got %0d required %0d", rd_rises, rd_exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
